// File: rtl/wide_mul_seq.sv
// wide_mul_seq: digit-serial WIDTH x WIDTH unsigned multiplier with a full
// 2*WIDTH-bit product. Feeds the 510-bit A input of modred in the fp_mul path.
// One DIGIT-wide slice of B is folded into the accumulator per compute cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   in_valid   operands A/B valid          in_ready   block can accept operands
//   A          multiplicand (WIDTH)        B          multiplier (WIDTH), LSB digit first
//   out_valid  product P valid             out_ready  downstream accepts P
//   P          product A*B (2*WIDTH), held until the next result, 0 after reset
//
// Build option:
//   WIDE_MUL_EARLY_EXIT_EN  finish as soon as all remaining B digits are zero
//                           (at least one compute cycle). Undefined: fixed NDIG cycles.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready=1
// MUL    | folding one B digit per cycle into the accumulator
// DONE   | product presented, out_valid=1 until out_ready
module wide_mul_seq #(
    parameter int WIDTH = 255,
    parameter int DIGIT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P
);

    localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int BW   = NDIG * DIGIT;
    localparam int ACCW = BW + WIDTH;
    localparam int PPW  = WIDTH + DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [BW-1:0]       b_q, b_d;
    logic [ACCW-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]  p_q, p_d;

    logic [DIGIT-1:0]    digit;
    logic [PPW-1:0]      pp;
    logic                last_digit;

    // Current digit of B and its single-cycle partial product
    assign digit = DIGIT'(b_q >> (int'(cnt_q) * DIGIT));
    assign pp    = a_q * digit;

`ifdef WIDE_MUL_EARLY_EXIT_EN
    // Stop once no nonzero digit remains above the one being processed now
    assign last_digit = (cnt_q == CW'(NDIG - 1)) ||
                        ((b_q >> (DIGIT * (int'(cnt_q) + 1))) == '0);
`else
    assign last_digit = (cnt_q == CW'(NDIG - 1));
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        p_d       = p_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = A;
                    b_d     = BW'(B);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = acc_q + (ACCW'(pp) << (DIGIT * int'(cnt_q)));
                cnt_d = cnt_q + CW'(1);
                if (last_digit) begin
                    // Capture the final sum directly so P is valid alongside out_valid
                    p_d     = acc_d[2*WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    assign P = p_q;

endmodule

// File: tb/tb_wide_mul_seq.sv
module tb_wide_mul_seq;

    localparam int W = 255;

`ifdef WIDE_MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] P;

    int n_vec = 0;
    int n_err = 0;

    wide_mul_seq #(.WIDTH(W), .DIGIT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    // Present one operand pair in IDLE, accept it, then count cycles until out_valid.
    // rdy_seen reports whether in_ready was seen high while waiting.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output bit to, output bit rdy_seen);
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0; to = 1'b1; rdy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                to = 1'b0;
                break;
            end
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++;
        if (P !== '0) begin n_err++; $display("FAIL reset_P got %h want 0", P); end
    endtask

    task automatic test_basic();
        int lat; bit to; bit rs;
        int want_lat;
        want_lat = EE ? 1 : 4;
        out_ready = 1'b1;
        run_op(255'd3, 255'd5, lat, to, rs);
        n_vec++;
        if (to || lat != want_lat) begin n_err++; $display("FAIL basic_latency got %0d (timeout %b) want %0d", lat, to, want_lat); end
        n_vec++;
        if (P !== 510'd15) begin n_err++; $display("FAIL basic_P got %h want 15", P); end
        n_vec++;
        if (rs || in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_busy got seen=%b now=%b want 0", rs, in_ready); end
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_after_handshake got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   a1, b1, a2, b2;
        logic [2*W-1:0] want1, want2;
        logic [2*W-1:0] outp [2];
        int acc_t [2];
        int nacc, nout;
        a1 = '1; b1 = '1; a2 = '1; b2 = 255'd1;
        want1 = '0 - (510'(1) << 256) + 510'd1;
        want2 = 510'(a2);
        nacc = 0; nout = 0;
        out_ready = 1'b1;
        @(negedge clk);
        A = a1; B = b1; in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (in_ready && in_valid && nacc < 2) begin acc_t[nacc] = c; nacc++; end
            if (out_valid && nout < 2) begin outp[nout] = P; nout++; end
            if (nacc == 2 && nout == 2) break;
            @(posedge clk);
            @(negedge clk);
            if (nacc == 1) begin A = a2; B = b2; end
            if (nacc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_vec++;
        if (nacc != 2 || nout != 2) begin
            n_err++; $display("FAIL b2b_timeout got accepts=%0d outputs=%0d want 2/2", nacc, nout);
        end else begin
            n_vec++;
            if (acc_t[1] - acc_t[0] != 6) begin n_err++; $display("FAIL b2b_interval got %0d want 6", acc_t[1] - acc_t[0]); end
            n_vec++;
            if (outp[0] !== want1) begin n_err++; $display("FAIL b2b_P_max got %h want %h", outp[0], want1); end
            n_vec++;
            if (outp[1] !== want2) begin n_err++; $display("FAIL b2b_P_one got %h want %h", outp[1], want2); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat; bit to; bit rs;
        logic [W-1:0]   b;
        logic [2*W-1:0] want;
        b = 255'(1) << 200;
        want = 510'd7 << 200;
        out_ready = 1'b0;
        run_op(255'd7, b, lat, to, rs);
        n_vec++;
        if (to || lat != 4) begin n_err++; $display("FAIL bp_latency got %0d (timeout %b) want 4", lat, to); end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            A = 255'd1; B = 255'd1;
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || P !== want || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d got out_valid=%b in_ready=%b P=%h want 1/0/%h", i, out_valid, in_ready, P, want);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== want) begin
            n_err++; $display("FAIL bp_release got in_ready=%b out_valid=%b P=%h want 1/0/%h", in_ready, out_valid, P, want);
        end
    endtask

    task automatic test_mid_reset();
        int lat; bit to; bit rs;
        bit seen;
        logic [W-1:0] b;
        b = EE ? (255'd11 | (255'(1) << 192)) : 255'd11;
        out_ready = 1'b1;
        @(negedge clk);
        A = 255'd9; B = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== '0) begin
            n_err++; $display("FAIL rst_mid got in_ready=%b out_valid=%b P=%h want 1/0/0", in_ready, out_valid, P);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL rst_no_output got out_valid=1 want 0"); end
        run_op(255'd2, 255'd2, lat, to, rs);
        n_vec++;
        if (to || P !== 510'd4) begin n_err++; $display("FAIL rst_next_op got P=%h (timeout %b) want 4", P, to); end
    endtask

    task automatic test_early_exit();
        int lat; bit to; bit rs;
        logic [W-1:0] a, b;
        a = 255'h1234_5678_9abc_def0_0fed_cba9;
        out_ready = 1'b1;
        run_op(a, 255'd5, lat, to, rs);
        n_vec++;
        if (to || lat != (EE ? 1 : 4) || P !== 510'(a) * 510'd5) begin
            n_err++; $display("FAIL ee_b5 got lat=%0d P=%h want lat=%0d P=%h", lat, P, EE ? 1 : 4, 510'(a) * 510'd5);
        end
        run_op(a, 255'd0, lat, to, rs);
        n_vec++;
        if (to || lat != (EE ? 1 : 4) || P !== '0) begin
            n_err++; $display("FAIL ee_b0 got lat=%0d P=%h want lat=%0d P=0", lat, P, EE ? 1 : 4);
        end
        b = 255'(1) << 192;
        run_op(a, b, lat, to, rs);
        n_vec++;
        if (to || lat != 4 || P !== (510'(a) << 192)) begin
            n_err++; $display("FAIL ee_b2p192 got lat=%0d P=%h want lat=4 P=%h", lat, P, 510'(a) << 192);
        end
    endtask

    task automatic test_random();
        int lat; bit to; bit rs;
        logic [255:0]   ra, rb;
        logic [2*W-1:0] golden;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) begin
                ra[j*32 +: 32] = $urandom;
                rb[j*32 +: 32] = $urandom;
            end
            golden = 510'(ra[W-1:0]) * 510'(rb[W-1:0]);
            run_op(ra[W-1:0], rb[W-1:0], lat, to, rs);
            n_vec++;
            if (to || P !== golden) begin
                n_err++; $display("FAIL rand_%0d got %h (timeout %b) want %h", k, P, to, golden);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_early_exit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wide_mul_seq.md
Name: wide_mul_seq

Overview:
- Digit-serial integer multiplier: WIDTH x WIDTH unsigned operands in, full 2*WIDTH-bit product out.
- Sits in front of modred and supplies its 510-bit input A from the 255-bit Fp operands of the fp_mul datapath.
- Trades throughput for area: one DIGIT-wide slice of B per cycle, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 255, operand width in bits.
- DIGIT, 64, bits of B consumed per compute cycle.
- NDIG, derived as ceil(WIDTH/DIGIT), 4 at defaults; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets the block.
- in_valid  in  1  operands A/B valid.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  multiplicand.
- B  in  WIDTH  multiplier, consumed DIGIT bits per cycle, LSB digit first.
- out_valid  out  1  product P valid.
- out_ready  in  1  downstream (modred) accepts P.
- P  out  2*WIDTH  product A*B.

Behaviour:
- Reset (rst==0 at edge):
  - state=IDLE, digit counter=0, accumulator=0.
  - P=0, out_valid=0, in_ready=1 from the next cycle.
  - Reset mid-operation aborts the multiply with no output.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid&&in_ready: latch A and B (zero-extended to NDIG*DIGIT), clear accumulator, counter=0, go to MUL.
- MUL:
  - in_ready=0. Each edge: acc <= acc + (A * B[counter digit]) << (DIGIT*counter), then counter++.
  - The edge that processes digit NDIG-1 goes to DONE.
- DONE:
  - out_valid=1, P=acc[2*WIDTH-1:0], held stable until the handshake.
  - On an edge with out_valid&&out_ready: go to IDLE.
  - No same-cycle accept of new operands while in DONE; in_ready goes high the cycle after the output handshake.
- Latency at defaults:
  - Accept at edge 0; digits processed at edges 1..4; out_valid high after edge 4.
  - 4 cycles from accept to out_valid.
  - Minimum initiation interval is NDIG+2 cycles (accept edge, NDIG compute edges, output-handshake edge) with out_ready tied high.
- Arithmetic:
  - Accumulator is NDIG*DIGIT+WIDTH bits wide, so it cannot overflow.
  - P is the low 2*WIDTH bits, exact since A*B < 2^(2*WIDTH).
  - The DIGIT x WIDTH partial product is a single-cycle combinational multiply.
- Inputs A/B are ignored outside the IDLE accept edge; changing them during MUL has no effect.
- in_valid may drop without acceptance; no state change.
- out_ready asserted while out_valid==0 has no effect.
- P holds its last value after the handshake until the next DONE; it is 0 after reset.

Optional Feature:
- Macro WIDE_MUL_EARLY_EXIT_EN.
- Defined:
  - In MUL, if every digit of B at and above counter+1 is zero, the current edge's update is the last and the state goes to DONE.
  - At least one compute edge always occurs, so B=0 still takes 1 cycle and yields P=0.
  - Latency becomes (index of highest nonzero digit of B)+1, minimum 1.
- Undefined: fixed NDIG-cycle latency with no zero detection logic.

Test Plan:
- Reset then A=3, B=5, out_ready=1 -> out_valid rises exactly 4 cycles after accept, P=15; in_ready=0 during MUL/DONE, in_ready=1 the cycle after the handshake.
- A=B=2^255-1 -> P=2^510-2^256+1. Back-to-back with A=2^255-1, B=1 -> P=2^255-1. Second accept no earlier than 6 cycles after the first.
- Backpressure: A=7, B=2^200, hold out_ready=0 for 10 cycles -> out_valid stays 1, P=7*2^200 stable; in_valid pulses ignored (in_ready=0); out_ready=1 -> handshake, IDLE next cycle.
- rst=0 for one edge at MUL digit 2 of A=9, B=11 -> out_valid never asserts for that op, P=0, in_ready=1 next cycle; new op A=2, B=2 -> P=4.
- Modred chain: A=random 255-bit, B=random 255-bit -> P equals the golden 510-bit product; feed P to modred and compare D with golden A*B mod p.
- With WIDE_MUL_EARLY_EXIT_EN: B=5 -> out_valid 1 cycle after accept, P=5*A; B=0 -> 1 cycle, P=0; B=2^192 -> 4 cycles. Without the macro, all three take 4 cycles.
